pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL provide parameter NUM_CLKS, default 2, number of downstream clock domains sequenced (1..8).
REQ-002 SHALL provide parameter PLL_RST_CYCLES, default 8, cycles pll_rst is held high per reset pulse.
REQ-003 SHALL provide parameter LOCK_TIMEOUT, default 4096, cycles allowed in WAIT_LOCK before retry.
REQ-004 SHALL provide parameter LOCK_STABLE_CYCLES, default 1024, consecutive synced-lock cycles required before release.
REQ-005 SHALL provide parameter STAGGER_CYCLES, default 16, spacing between successive domain reset releases.
REQ-006 SHALL provide parameter MAX_RETRY, default 3, consecutive failed attempts before FAULT.
REQ-007 SHALL have ports: refclk in 1 sole clock; rst_n in 1 synchronous active-low reset (one clock; reset is synchronous and active-low).
REQ-008 SHALL have ports: pll_locked in 1 asynchronous PLL lock; clear_fault in 1 single-cycle fault clear.
REQ-009 SHALL have ports: pll_rst out 1 active-high PLL reset; domain_rst_n out NUM_CLKS per-domain active-low reset.
REQ-010 SHALL have ports: all_ready out 1; fault out 1; state out 3 encoded FSM state; retry_cnt out clog2(MAX_RETRY+1).

Function
REQ-011 SHALL synchronise pll_locked through two refclk flops (locked_s); all decisions use locked_s only (2-cycle latency).
REQ-012 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
REQ-013 RESET_PLL: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK; all domain_rst_n=0.
REQ-014 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; LOCK_TIMEOUT cycles without lock -> retry_cnt+1, RESET_PLL.
REQ-015 STABLE: count consecutive locked_s cycles; reaching LOCK_STABLE_CYCLES -> RELEASE; locked_s=0 -> WAIT_LOCK, count cleared, retry_cnt unchanged.
REQ-016 RELEASE: domain_rst_n[i] rises exactly i*STAGGER_CYCLES cycles after RELEASE entry (bit 0 on entry cycle), index order; once set, remains set until lock loss.
REQ-017 RELEASE -> RUN on the cycle after the last domain releases; retry_cnt cleared to 0 on RUN entry.
REQ-018 RUN: all_ready=1 (only in RUN), all domain_rst_n=1.
REQ-019 Lock loss (locked_s=0) in RELEASE or RUN: all domain_rst_n=0 and all_ready=0 on the next edge; retry_cnt+1; -> RESET_PLL.
REQ-020 Any increment making retry_cnt equal MAX_RETRY SHALL enter FAULT instead of RESET_PLL; retry_cnt saturates at MAX_RETRY.
REQ-021 FAULT: pll_rst=1, fault=1, domain_rst_n=0; pll_locked ignored; clear_fault=1 -> retry_cnt=0, RESET_PLL next cycle.
REQ-022 clear_fault outside FAULT SHALL be ignored.
REQ-023 All outputs SHALL be registered; no combinational path from pll_locked or clear_fault to any output.

Reset
REQ-024 rst_n=0 sampled at a refclk edge SHALL force RESET_PLL with counters cleared, retry_cnt=0, pll_rst=1, domain_rst_n=0, all_ready=0, fault=0, sync flops 0.
REQ-025 rst_n asserted mid-sequence (any state, including FAULT) SHALL abort immediately with the values of REQ-024; full PLL_RST_CYCLES pulse restarts after deassertion.

Structure
REQ-026 State encoding typedef, state code constants and a clog2 helper SHALL reside in shared package pll_supervisor_pkg.
REQ-027 The 2-flop synchroniser SHALL be sub-module sync_2ff, reusable elsewhere; FSM and counters stay in pll_lock_supervisor.
REQ-028 One shared down-counter SHALL serve RESET_PLL, WAIT_LOCK, STABLE and RELEASE timing; width from the largest parameter.

Verification (NUM_CLKS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4, MAX_RETRY=2)
REQ-029 Clean bring-up: pll_locked=1 at cycle 10 -> pll_rst high cycles 0-3; domain_rst_n bits rise 0/4/8 cycles after RELEASE entry; all_ready one cycle after bit 2.
REQ-030 Glitch in STABLE: pll_locked low 3 cycles after 5 stable cycles -> back to WAIT_LOCK, retry_cnt stays 0, stable count restarts from 0.
REQ-031 Lock loss in RUN: pll_locked drops -> domain_rst_n=3'b000 within 3 edges of the drop, retry_cnt=1, new 4-cycle pll_rst pulse.
REQ-032 Never lock: pll_locked=0 -> two 64-cycle timeouts, retry_cnt=2, fault=1, pll_rst held; clear_fault pulse -> RESET_PLL, retry_cnt=0.
REQ-033 Reset mid-RELEASE: rst_n=0 after domain 1 released -> next edge all outputs per REQ-024; sequence restarts cleanly.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: state codes, state type and
// width helpers used to size counters from parameters.
package pll_supervisor_pkg;

    localparam logic [2:0] ST_CODE_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_CODE_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_CODE_STABLE    = 3'd2;
    localparam logic [2:0] ST_CODE_RELEASE   = 3'd3;
    localparam logic [2:0] ST_CODE_RUN       = 3'd4;
    localparam logic [2:0] ST_CODE_FAULT     = 3'd5;

    typedef enum logic [2:0] {
        ST_RESET_PLL = ST_CODE_RESET_PLL,
        ST_WAIT_LOCK = ST_CODE_WAIT_LOCK,
        ST_STABLE    = ST_CODE_STABLE,
        ST_RELEASE   = ST_CODE_RELEASE,
        ST_RUN       = ST_CODE_RUN,
        ST_FAULT     = ST_CODE_FAULT
    } sup_state_e;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level signals, with a
// synchronous active-low clear.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, qualifies lock, then releases
// the downstream domain resets in staggered order; retries and faults out.
//
// state      | meaning
// RESET_PLL  | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK  | waiting for synced lock, LOCK_TIMEOUT budget
// STABLE     | lock must hold for LOCK_STABLE_CYCLES consecutive cycles
// RELEASE    | domain resets released one by one, STAGGER_CYCLES apart
// RUN        | all domains out of reset, all_ready high
// FAULT      | MAX_RETRY failed attempts; waits for clear_fault
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int NUM_CLKS           = 2,
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 16,
    parameter int MAX_RETRY          = 3
) (
    input  logic                          refclk,
    input  logic                          rst_n,
    input  logic                          pll_locked,
    input  logic                          clear_fault,
    output logic                          pll_rst,
    output logic [NUM_CLKS-1:0]           domain_rst_n,
    output logic                          all_ready,
    output logic                          fault,
    output logic [2:0]                    state,
    output logic [clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int CNT_W = clog2(max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                         LOCK_STABLE_CYCLES, STAGGER_CYCLES));
    localparam int RTY_W = clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE      = RTY_W'(1);
    localparam logic [NUM_CLKS-1:0] DOM_FIRST = NUM_CLKS'(1);

    sup_state_e       cur_state;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;
    logic [RTY_W-1:0] retry_inc;
    logic             retry_exhausted;
    logic             attempt_fail;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // A failed attempt is either a lock timeout or lock loss after release began.
    always_comb begin
        retry_inc       = (retry_cnt >= RTY_MAX) ? retry_cnt : retry_cnt + RTY_ONE;
        retry_exhausted = (retry_inc == RTY_MAX);
        attempt_fail    = !locked_s &&
                          (((cur_state == ST_WAIT_LOCK) && (cnt == '0)) ||
                           (cur_state == ST_RELEASE) || (cur_state == ST_RUN));
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            cur_state    <= ST_RESET_PLL;
            cnt          <= RST_LOAD;
            retry_cnt    <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            all_ready    <= 1'b0;
            fault        <= 1'b0;
        end else if (attempt_fail) begin
            cur_state    <= retry_exhausted ? ST_FAULT : ST_RESET_PLL;
            cnt          <= RST_LOAD;
            retry_cnt    <= retry_inc;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            all_ready    <= 1'b0;
            fault        <= retry_exhausted;
        end else begin
            case (cur_state)
                ST_RESET_PLL: begin
                    if (cnt == '0) begin
                        cur_state <= ST_WAIT_LOCK;
                        cnt       <= TIMEOUT_LOAD;
                        pll_rst   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        cur_state <= ST_STABLE;
                        cnt       <= STABLE_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        cur_state <= ST_WAIT_LOCK;
                        cnt       <= TIMEOUT_LOAD;
                    end else if (cnt == '0) begin
                        cur_state    <= ST_RELEASE;
                        cnt          <= STAGGER_LOAD;
                        domain_rst_n <= DOM_FIRST;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    // domain_rst_n fills from bit 0 upward, one bit per stagger period
                    if (&domain_rst_n) begin
                        cur_state <= ST_RUN;
                        all_ready <= 1'b1;
                        retry_cnt <= '0;
                    end else if (cnt == '0) begin
                        domain_rst_n <= (domain_rst_n << 1) | DOM_FIRST;
                        cnt          <= STAGGER_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    all_ready <= 1'b1;
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        cur_state <= ST_RESET_PLL;
                        cnt       <= RST_LOAD;
                        retry_cnt <= '0;
                        fault     <= 1'b0;
                    end
                end
                default: begin
                    cur_state    <= ST_RESET_PLL;
                    cnt          <= RST_LOAD;
                    pll_rst      <= 1'b1;
                    domain_rst_n <= '0;
                    all_ready    <= 1'b0;
                    fault        <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed bring-up scenarios plus
// randomized lock/clear/reset traffic against a phase-and-age reference model.
module tb_pll_lock_supervisor;
    import pll_supervisor_pkg::*;

    localparam int NUM_CLKS           = 3;
    localparam int PLL_RST_CYCLES     = 4;
    localparam int LOCK_TIMEOUT       = 64;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int STAGGER_CYCLES     = 4;
    localparam int MAX_RETRY          = 2;
    localparam int RW                 = clog2(MAX_RETRY + 1);

    logic                refclk = 1'b0;
    logic                rst_n;
    logic                pll_locked;
    logic                clear_fault;
    logic                pll_rst;
    logic [NUM_CLKS-1:0] domain_rst_n;
    logic                all_ready;
    logic                fault;
    logic [2:0]          state;
    logic [RW-1:0]       retry_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    pll_lock_supervisor #(
        .NUM_CLKS           (NUM_CLKS),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_TIMEOUT       (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .STAGGER_CYCLES     (STAGGER_CYCLES),
        .MAX_RETRY          (MAX_RETRY)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .clear_fault  (clear_fault),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .all_ready    (all_ready),
        .fault        (fault),
        .state        (state),
        .retry_cnt    (retry_cnt)
    );

    always #5 refclk = ~refclk;

    // Reference model: current phase, cycles spent in it, retry count, and the
    // two-cycle history of pll_locked seen by the synchroniser.
    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RELEASE = 3, P_RUN = 4, P_FAULT = 5;
    int m_phase, m_age, m_retry;
    bit m_s1, m_s2;

    task automatic model_enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_fail();
        m_retry = (m_retry < MAX_RETRY) ? m_retry + 1 : MAX_RETRY;
        model_enter((m_retry == MAX_RETRY) ? P_FAULT : P_RESET);
    endtask

    task automatic model_step();
        bit seen;
        if (!rst_n) begin
            model_enter(P_RESET);
            m_retry = 0;
            m_s1    = 0;
            m_s2    = 0;
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        case (m_phase)
            P_RESET:   if (m_age == PLL_RST_CYCLES - 1) model_enter(P_WAIT); else m_age++;
            P_WAIT:    if (seen) model_enter(P_STABLE);
                       else if (m_age == LOCK_TIMEOUT - 1) model_fail();
                       else m_age++;
            P_STABLE:  if (!seen) model_enter(P_WAIT);
                       else if (m_age == LOCK_STABLE_CYCLES - 1) model_enter(P_RELEASE);
                       else m_age++;
            P_RELEASE: if (!seen) model_fail();
                       else if (m_age == (NUM_CLKS - 1) * STAGGER_CYCLES) begin
                           model_enter(P_RUN);
                           m_retry = 0;
                       end else m_age++;
            P_RUN:     if (!seen) model_fail();
            default:   if (clear_fault) begin
                           model_enter(P_RESET);
                           m_retry = 0;
                       end
        endcase
    endtask

    function automatic logic [2:0] exp_state();
        case (m_phase)
            P_RESET:   return ST_RESET_PLL;
            P_WAIT:    return ST_WAIT_LOCK;
            P_STABLE:  return ST_STABLE;
            P_RELEASE: return ST_RELEASE;
            P_RUN:     return ST_RUN;
            default:   return ST_FAULT;
        endcase
    endfunction

    function automatic logic [NUM_CLKS-1:0] exp_dom();
        logic [NUM_CLKS-1:0] d = '0;
        for (int i = 0; i < NUM_CLKS; i++)
            d[i] = (m_phase == P_RUN) || ((m_phase == P_RELEASE) && (m_age >= i * STAGGER_CYCLES));
        return d;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        cyc++;
        @(negedge refclk);
        chk("state",        16'(state),        16'(exp_state()));
        chk("pll_rst",      16'(pll_rst),      16'(m_phase == P_RESET || m_phase == P_FAULT));
        chk("fault",        16'(fault),        16'(m_phase == P_FAULT));
        chk("all_ready",    16'(all_ready),    16'(m_phase == P_RUN));
        chk("domain_rst_n", 16'(domain_rst_n), 16'(exp_dom()));
        chk("retry_cnt",    16'(retry_cnt),    16'(m_retry));
    endtask

    initial begin
        int pulse, rel_at, ready_at, edges, stable_cycles, fault_at, run_left;
        int rise [NUM_CLKS];
        bit saw_wait, lvl;

        rst_n       = 1'b0;
        pll_locked  = 1'b0;
        clear_fault = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Clean bring-up, lock appears at cycle 10 after reset.
        pulse = 0; rel_at = -1; ready_at = -1;
        foreach (rise[i]) rise[i] = -1;
        for (int c = 0; c < 200 && ready_at < 0; c++) begin
            if (pll_rst) pulse++;
            if (state == ST_RELEASE && rel_at < 0) rel_at = c;
            for (int i = 0; i < NUM_CLKS; i++)
                if (domain_rst_n[i] && rise[i] < 0) rise[i] = c;
            if (all_ready) ready_at = c;
            pll_locked = (c >= 10);
            if (ready_at < 0) tick();
        end
        chk("bringup_reached_run", 16'(ready_at >= 0), 16'(1));
        chk("bringup_pll_rst_len", 16'(pulse), 16'(PLL_RST_CYCLES));
        for (int i = 0; i < NUM_CLKS; i++)
            chk("bringup_stagger", 16'(rise[i] - rel_at), 16'(i * STAGGER_CYCLES));
        chk("bringup_ready_delay", 16'(ready_at - rise[NUM_CLKS-1]), 16'(1));

        // Lock glitch while in STABLE.
        rst_n = 1'b0; pll_locked = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 100 && !(m_phase == P_STABLE && m_age == 3); c++) tick();
        chk("glitch_in_stable", 16'(state), 16'(ST_STABLE));
        pll_locked = 1'b0;
        tick(); tick(); tick();
        pll_locked = 1'b1;
        saw_wait = (state == ST_WAIT_LOCK);
        stable_cycles = 0;
        for (int c = 0; c < 100 && !all_ready; c++) begin
            tick();
            if (state == ST_WAIT_LOCK) saw_wait = 1'b1;
            else if (saw_wait && state == ST_STABLE) stable_cycles++;
        end
        chk("glitch_back_to_wait", 16'(saw_wait), 16'(1));
        chk("glitch_stable_restart", 16'(stable_cycles), 16'(LOCK_STABLE_CYCLES));
        chk("glitch_retry", 16'(retry_cnt), 16'(0));
        chk("glitch_reached_run", 16'(all_ready), 16'(1));

        // Lock loss in RUN.
        pll_locked = 1'b0;
        edges = 0;
        for (int e = 1; e <= 6 && edges == 0; e++) begin
            tick();
            if (domain_rst_n == '0) edges = e;
        end
        chk("loss_edges", 16'(edges), 16'(3));
        chk("loss_retry", 16'(retry_cnt), 16'(1));
        pulse = 0;
        for (int c = 0; c < 20 && pll_rst; c++) begin
            pulse++;
            tick();
        end
        chk("loss_pll_rst_len", 16'(pulse), 16'(PLL_RST_CYCLES));
        pll_locked = 1'b1;
        for (int c = 0; c < 100 && !all_ready; c++) tick();
        chk("loss_recovered", 16'(all_ready), 16'(1));
        chk("loss_retry_cleared", 16'(retry_cnt), 16'(0));

        // Never lock: two timeouts then FAULT; stray clear_fault in WAIT_LOCK.
        rst_n = 1'b0; pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        fault_at = -1;
        for (int c = 0; c < 400 && fault_at < 0; c++) begin
            clear_fault = (c == 30);
            if (fault) fault_at = c;
            else tick();
        end
        clear_fault = 1'b0;
        chk("nolock_fault_time", 16'(fault_at), 16'(MAX_RETRY * (PLL_RST_CYCLES + LOCK_TIMEOUT)));
        chk("nolock_retry", 16'(retry_cnt), 16'(MAX_RETRY));
        chk("nolock_pll_rst", 16'(pll_rst), 16'(1));
        for (int c = 0; c < 10; c++) begin
            pll_locked = 1'($urandom_range(0, 1));
            tick();
        end
        chk("fault_holds", 16'(fault), 16'(1));
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_state", 16'(state), 16'(ST_RESET_PLL));
        chk("clear_retry", 16'(retry_cnt), 16'(0));
        chk("clear_fault_low", 16'(fault), 16'(0));

        // Reset in the middle of RELEASE.
        pll_locked = 1'b1;
        for (int c = 0; c < 200 && domain_rst_n != 3'b011; c++) tick();
        chk("midrel_reached", 16'(domain_rst_n), 16'(3'b011));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrel_state", 16'(state), 16'(ST_RESET_PLL));
        chk("midrel_dom", 16'(domain_rst_n), 16'(0));
        chk("midrel_pll_rst", 16'(pll_rst), 16'(1));
        for (int c = 0; c < 100 && !all_ready; c++) tick();
        chk("midrel_restart_run", 16'(all_ready), 16'(1));

        // Randomized lock runs, clear pulses and occasional resets.
        run_left = 0;
        lvl = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                lvl = ($urandom_range(0, 3) != 0);
                run_left = $urandom_range(1, 90);
            end
            run_left--;
            pll_locked  = lvl;
            clear_fault = ($urandom_range(0, 19) == 0);
            rst_n       = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
